// File: rtl/online_qsel_pipe.sv
// Online division quotient-digit selection stage: picks a radix-2 signed digit
// from a truncated redundant residual window and streams N_DIGITS digits per division.
module online_qsel_pipe #(
  parameter int unsigned W        = 4,
  parameter int unsigned N_DIGITS = 16,
  localparam int unsigned CW      = $clog2(N_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  v_plus,
  input  logic [W-1:0]  v_minus,
  input  logic          borrow_in,
  input  logic          fixing,
  input  logic [1:0]    pre_p,
  output logic          q_valid,
  output logic [1:0]    q_digit,
  output logic [CW-1:0] digit_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0]    DIG_POS  = 2'b10;
  localparam logic [1:0]    DIG_ZERO = 2'b00;
  localparam logic [1:0]    DIG_NEG  = 2'b01;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [1:0]    dig_q, dig_d;
  logic          qv_q, qv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  win_c;
  logic [1:0]    sel_c;

  // Digit selection: wrapped window compared against +1 / {0,-1} / <=-2 bands.
  always_comb begin
    sel_c = DIG_ZERO;
    win_c = v_plus - v_minus - W'(borrow_in);
    if (fixing) begin
      sel_c = (pre_p == 2'b11) ? DIG_ZERO : pre_p;
    end else if (!win_c[W-1] && (win_c != '0)) begin
      sel_c = DIG_POS;
    end else if ((win_c == '0) || (&win_c)) begin
      sel_c = DIG_ZERO;
    end else begin
      sel_c = DIG_NEG;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    qv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          qv_d  = 1'b1;
          dig_d = sel_c;
          idx_d = cnt_q;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    // DONE is entered alongside the last q_valid, so done lands one cycle later.
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= DIG_ZERO;
      qv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      qv_q    <= qv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q_valid   = qv_q;
  assign q_digit   = dig_q;
  assign digit_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_online_qsel_pipe.sv
// Directed bench for online_qsel_pipe (W=4, N_DIGITS=4): vector table plus
// hand-written sequences for gaps, start/in_valid overlap and mid-run reset.
module tb_online_qsel_pipe;

  localparam int unsigned W  = 4;
  localparam int unsigned ND = 4;
  localparam int unsigned CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  v_plus;
  logic [W-1:0]  v_minus;
  logic          borrow_in;
  logic          fixing;
  logic [1:0]    pre_p;
  logic          q_valid;
  logic [1:0]    q_digit;
  logic [CW-1:0] digit_idx;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  online_qsel_pipe #(.W(W), .N_DIGITS(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .v_plus(v_plus), .v_minus(v_minus), .borrow_in(borrow_in),
    .fixing(fixing), .pre_p(pre_p), .q_valid(q_valid), .q_digit(q_digit),
    .digit_idx(digit_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] vp;
    logic [W-1:0] vm;
    logic         b;
    logic         fx;
    logic [1:0]   pp;
    logic [1:0]   exp_dig;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present one residual window with in_valid for a single cycle; returns at posedge+1.
  task automatic apply(input logic [W-1:0] vp, input logic [W-1:0] vm, input logic b,
                       input logic fx, input logic [1:0] pp);
    v_plus = vp; v_minus = vm; borrow_in = b; fixing = fx; pre_p = pp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fixing   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    vecs[0]  = '{4'd5,  4'd2, 1'b0, 1'b0, 2'b00, 2'b10}; // v=+3
    vecs[1]  = '{4'd3,  4'd3, 1'b1, 1'b0, 2'b00, 2'b00}; // v=-1
    vecs[2]  = '{4'd0,  4'd8, 1'b0, 1'b0, 2'b00, 2'b01}; // v=-8
    vecs[3]  = '{4'd5,  4'd2, 1'b0, 1'b1, 2'b01, 2'b01}; // forced -1
    vecs[4]  = '{4'd5,  4'd2, 1'b0, 1'b1, 2'b11, 2'b00}; // forced 11 -> 0
    vecs[5]  = '{4'd2,  4'd3, 1'b0, 1'b0, 2'b00, 2'b00}; // v=-1
    vecs[6]  = '{4'd0,  4'd2, 1'b0, 1'b0, 2'b00, 2'b01}; // v=-2
    vecs[7]  = '{4'd7,  4'd6, 1'b0, 1'b0, 2'b00, 2'b10}; // v=+1
    vecs[8]  = '{4'd3,  4'd3, 1'b0, 1'b0, 2'b00, 2'b00}; // v=0
    vecs[9]  = '{4'd15, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00}; // 15 wraps to -1
    vecs[10] = '{4'd0,  4'd9, 1'b0, 1'b0, 2'b00, 2'b10}; // -9 wraps to +7
    vecs[11] = '{4'd0,  4'd8, 1'b0, 1'b1, 2'b10, 2'b10}; // forced +1 over v=-8

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; v_plus = '0; v_minus = '0;
    borrow_in = 1'b0; fixing = 1'b0; pre_p = 2'b00;
    #2;
    check("rst_q_valid", int'(q_valid), 0);
    check("rst_q_digit", int'(q_digit), 0);
    check("rst_digit_idx", int'(digit_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    #18 reset = 1'b0;
    @(posedge clk); #1;

    // Table: three back-to-back divisions of four consecutive digits.
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin
        do_start();
        check("tbl_busy_after_start", int'(busy), 1);
        check("tbl_no_qv_after_start", int'(q_valid), 0);
      end
      apply(vecs[i].vp, vecs[i].vm, vecs[i].b, vecs[i].fx, vecs[i].pp);
      check($sformatf("tbl%0d_q_valid", i), int'(q_valid), 1);
      check($sformatf("tbl%0d_q_digit", i), int'(q_digit), int'(vecs[i].exp_dig));
      check($sformatf("tbl%0d_digit_idx", i), int'(digit_idx), i % 4);
      if (i % 4 == 3) begin
        check($sformatf("tbl%0d_done_not_yet", i), int'(done), 0);
        check($sformatf("tbl%0d_busy_low", i), int'(busy), 0);
        idle_cycle();
        check($sformatf("tbl%0d_done", i), int'(done), 1);
        check($sformatf("tbl%0d_qv_low", i), int'(q_valid), 0);
        idle_cycle();
        check($sformatf("tbl%0d_done_pulse", i), int'(done), 0);
      end
    end

    // start with in_valid in IDLE: window ignored, division begins.
    v_plus = 4'd5; v_minus = 4'd2; borrow_in = 1'b0;
    start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check("ovl_no_q_valid", int'(q_valid), 0);
    check("ovl_busy", int'(busy), 1);

    // Non-consecutive digits with idle gaps that must hold outputs.
    apply(4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    check("gap0_qv", int'(q_valid), 1);
    check("gap0_dig", int'(q_digit), 2);
    check("gap0_idx", int'(digit_idx), 0);
    idle_cycle();
    check("gap0_hold_qv", int'(q_valid), 0);
    check("gap0_hold_dig", int'(q_digit), 2);
    check("gap0_hold_idx", int'(digit_idx), 0);
    idle_cycle();
    apply(4'd0, 4'd8, 1'b0, 1'b0, 2'b00);
    check("gap1_dig", int'(q_digit), 1);
    check("gap1_idx", int'(digit_idx), 1);
    idle_cycle();
    check("gap1_hold_idx", int'(digit_idx), 1);
    check("gap1_busy", int'(busy), 1);
    apply(4'd3, 4'd3, 1'b1, 1'b0, 2'b00);
    check("gap2_qv", int'(q_valid), 1);
    check("gap2_dig", int'(q_digit), 0);
    check("gap2_idx", int'(digit_idx), 2);
    idle_cycle();
    idle_cycle();
    check("gap2_no_done", int'(done), 0);
    apply(4'd7, 4'd6, 1'b0, 1'b0, 2'b00);
    check("gap3_dig", int'(q_digit), 2);
    check("gap3_idx", int'(digit_idx), 3);
    idle_cycle();
    check("gap_done", int'(done), 1);
    check("gap_busy_low", int'(busy), 0);
    apply(4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    check("fifth_no_qv", int'(q_valid), 0);
    check("fifth_no_done", int'(done), 0);
    check("fifth_busy", int'(busy), 0);

    // Reset after two digits aborts the division without a done pulse.
    do_start();
    apply(4'd0, 4'd2, 1'b0, 1'b0, 2'b00);
    apply(4'd5, 4'd2, 1'b0, 1'b0, 2'b00);
    check("pre_rst_idx", int'(digit_idx), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_qv", int'(q_valid), 0);
    check("mid_rst_dig", int'(q_digit), 0);
    check("mid_rst_idx", int'(digit_idx), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    #2 reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      idle_cycle();
      if (done) dones++;
    end
    check("rst_abort_no_done", dones, 0);
    check("rst_abort_busy", int'(busy), 0);

    do_start();
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      apply(4'd7, 4'd6, 1'b0, 1'b0, 2'b00);
      check($sformatf("restart%0d_idx", k), int'(digit_idx), k);
      if (done) dones++;
    end
    for (int c = 0; c < 4; c++) begin
      idle_cycle();
      if (done) dones++;
    end
    check("restart_done_once", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/online_qsel_pipe.md
ONLINE_QSEL_PIPE -- requirements
Module: online_qsel_pipe

Parameters
REQ-001 The block SHALL have parameter W, default 4, meaning the bit width of the residual window (W >= 3).
REQ-002 The block SHALL have parameter N_DIGITS, default 16, meaning the quotient digits produced per division (N_DIGITS >= 2).
REQ-003 The block SHALL have localparam CW = $clog2(N_DIGITS+1), meaning the digit counter width.

Interface
REQ-004 clk  input  1  system clock; one clock, all state on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin a new division; sampled only in IDLE.
REQ-007 in_valid  input  1  residual window valid this cycle.
REQ-008 v_plus  input  W  positive component of the redundant residual window.
REQ-009 v_minus  input  W  negative component of the redundant residual window.
REQ-010 borrow_in  input  1  borrow from the lower residual bits.
REQ-011 fixing  input  1  override: digit taken from pre_p instead of selection.
REQ-012 pre_p  input  2  forced digit code used when fixing=1.
REQ-013 q_valid  output  1  q_digit valid, one-cycle pulse per digit.
REQ-014 q_digit  output  2  digit code: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1; 2'b11 never driven.
REQ-015 digit_idx  output  CW  index of the digit on q_digit, 0 for the first digit.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse in the cycle after the last digit's q_valid.

Function
REQ-018 Window value SHALL be v = (v_plus - v_minus - borrow_in) mod 2^W, interpreted as W-bit two's complement.
REQ-019 Selection SHALL be: v >= 1 -> 2'b10; v = 0 or v = -1 -> 2'b00; v <= -2 -> 2'b01.
REQ-020 When fixing=1, the digit SHALL be pre_p, with pre_p=2'b11 mapped to 2'b00.
REQ-021 FSM states SHALL be IDLE, RUN and DONE.
REQ-022 In IDLE, start=1 SHALL go to RUN, clear the counter to 0 and ignore in_valid in that cycle.
REQ-023 In RUN, each cycle with in_valid=1 SHALL register the digit, assert q_valid the next cycle with digit_idx = counter, and increment the counter.
REQ-024 In RUN, cycles with in_valid=0 SHALL hold q_digit and digit_idx, with q_valid=0.
REQ-025 When the accepted digit has counter = N_DIGITS-1, the FSM SHALL go to DONE.
REQ-026 DONE SHALL last exactly one cycle, assert done, and then return to IDLE.
REQ-027 start SHALL be ignored in RUN and DONE; in_valid SHALL be ignored in IDLE and DONE.
REQ-028 Latency SHALL be 1 cycle from an accepted in_valid to q_valid; throughput SHALL be 1 digit per cycle.
REQ-029 Subtraction SHALL wrap modulo 2^W, with no saturation; out-of-range residuals are the caller's responsibility.
REQ-030 fixing SHALL affect only the digit being accepted in that cycle and have no persistent effect.

Reset
REQ-031 When reset is asserted, the block SHALL immediately force IDLE, counter=0, q_digit=2'b00, digit_idx=0, q_valid=0, busy=0, done=0.
REQ-032 Reset in the middle of RUN SHALL abort the division with no done pulse; the first start after reset SHALL begin a fresh division at digit_idx=0.

Verification
REQ-033 W=4: v_plus=4'd5, v_minus=4'd2, borrow_in=0, in RUN -> next cycle q_valid=1, q_digit=2'b10.
REQ-034 W=4: v_plus=4'd3, v_minus=4'd3, borrow_in=1 (v=-1) -> q_digit=2'b00; with v_plus=4'd0, v_minus=4'd8 (v=-8) -> q_digit=2'b01.
REQ-035 Fixing: fixing=1, pre_p=2'b01, window v=+3 -> q_digit=2'b01; pre_p=2'b11 -> q_digit=2'b00.
REQ-036 N_DIGITS=4: start, then in_valid on 4 non-consecutive cycles -> q_valid with digit_idx 0,1,2,3, done one cycle after the idx-3 pulse, busy low afterwards; a 5th in_valid produces no q_valid.
REQ-037 Reset after 2 of 4 digits -> all outputs 0 asynchronously and no done; then start plus 4 digits -> digit_idx restarts at 0 and done pulses once.
REQ-038 start and in_valid asserted together in IDLE -> no q_valid next cycle and busy=1.
